// File: rtl/timer_ctl.sv
// ---------------------------------------------------------------------------
// timer_ctl
//
// Autonomous sequencer that owns the 2-bit register port of a 16-bit timer.
// The CPU programs a reload value and a mode through a small register map.
// The controller then stops, loads, starts and polls the timer on its own.
// Expiry is latched into a pending flag, which raises irq when enabled.
// Periodic mode reloads and restarts the timer after every expiry.
//
// CPU register map:
//   0  RELOAD[7:0]   RW
//   1  RELOAD[15:8]  RW
//   2  CTRL          RW  {5'b0, irq_en, periodic, run}
//   3  STAT          R   {pend, ovr, 4'b0, busy, run}
//                    W   bit7=1 clears pend, bit6=1 clears ovr
//
// Optional feature, enabled by defining TIMER_CTL_OVERRUN_EN:
//   STAT bit6 (ovr) becomes a sticky overrun flag. It is set when the timer
//   expires while pend is already 1. With the macro undefined, bit6 reads 0
//   and no flop is built.
//
// Parameters:
//   RELOAD_RST  reset value of the reload register
//   CTRL_RST    reset value of CTRL[2:0] {irq_en, periodic, run}
//
// Ports:
//   clk     in   1  clock
//   rst     in   1  reset, asynchronous, active-high
//   cs      in   1  CPU chip select
//   we      in   1  CPU write(1) / read(0)
//   addr    in   2  CPU register select
//   dbw     in   8  CPU write data
//   dbr     out  8  CPU read data, registered (1-clk latency)
//   irq     out  1  interrupt request = pend & irq_en
//   t_addr  out  2  timer register select
//   t_we    out  1  timer write strobe
//   t_dbw   out  8  timer write data
//   t_dbr   in   8  timer read data (registered inside the timer)
// ---------------------------------------------------------------------------
module timer_ctl #(
    parameter logic [15:0] RELOAD_RST = 16'hFFFF,
    parameter logic [2:0]  CTRL_RST   = 3'b000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       we,
    input  logic [1:0] addr,
    input  logic [7:0] dbw,
    output logic [7:0] dbr,
    output logic       irq,
    output logic [1:0] t_addr,
    output logic       t_we,
    output logic [7:0] t_dbw,
    input  logic [7:0] t_dbr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STOP,
        S_LD_LO,
        S_LD_HI,
        S_START,
        S_POLL
    } state_e;

    // CTRL bit positions
    localparam int unsigned C_RUN    = 0;
    localparam int unsigned C_PERIOD = 1;
    localparam int unsigned C_IRQEN  = 2;

    state_e      state_q, state_d;
    logic        halt_q, halt_d;
    logic        poll_valid_q, poll_valid_d;
    logic [15:0] reload_q, reload_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic        pend_q, pend_d;
    logic [7:0]  dbr_q, dbr_d;

    logic        rd_en;
    logic        wr_en;
    logic        ctrl_wr;
    logic        stat_wr;
    logic        expire;
    logic        busy;
    logic        ovr;
    logic [7:0]  rdata;

    // Only the expiry flag of the timer status is of interest here.
    logic        unused_t_dbr;
    assign unused_t_dbr = ^t_dbr[6:0];

    // -----------------------------------------------------------------------
    // CPU access decode
    // -----------------------------------------------------------------------
    always_comb begin
        rd_en   = cs & ~we;
        wr_en   = cs & we;
        ctrl_wr = wr_en & (addr == 2'd2);
        stat_wr = wr_en & (addr == 2'd3);
    end

    // t_dbr lags the timer by one clock and is stale right after the
    // write cycles, so it is only trusted from the second POLL cycle on.
    assign expire = (state_q == S_POLL) & poll_valid_q & t_dbr[7];
    assign busy   = (state_q != S_IDLE);

    // -----------------------------------------------------------------------
    // Sequencer: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        halt_d       = halt_q;
        poll_valid_d = poll_valid_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end
            S_STOP: begin
                state_d = halt_q ? S_IDLE : S_LD_LO;
            end
            S_LD_LO: begin
                state_d = S_LD_HI;
            end
            S_LD_HI: begin
                state_d = S_START;
            end
            S_START: begin
                state_d      = S_POLL;
                poll_valid_d = 1'b0;
            end
            S_POLL: begin
                poll_valid_d = 1'b1;
                if (expire) begin
                    state_d = S_STOP;
                    // One-shot mode halts after the stop write.
                    halt_d  = ~ctrl_q[C_PERIOD];
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A CTRL write overrides whatever the sequencer was about to do,
        // including a coincident expiry.
        if (ctrl_wr) begin
            if (dbw[C_RUN]) begin
                state_d = S_STOP;
                halt_d  = 1'b0;
            end else if (state_q != S_IDLE) begin
                state_d = S_STOP;
                halt_d  = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Timer port, decoded from the state register only
    // -----------------------------------------------------------------------
    always_comb begin
        t_we   = 1'b0;
        t_addr = 2'd2;
        t_dbw  = '0;
        case (state_q)
            S_STOP: begin
                t_we   = 1'b1;
                t_addr = 2'd2;
                t_dbw  = 8'h00;
            end
            S_LD_LO: begin
                t_we   = 1'b1;
                t_addr = 2'd0;
                t_dbw  = reload_q[7:0];
            end
            S_LD_HI: begin
                t_we   = 1'b1;
                t_addr = 2'd1;
                t_dbw  = reload_q[15:8];
            end
            S_START: begin
                t_we   = 1'b1;
                t_addr = 2'd2;
                t_dbw  = 8'h01;
            end
            default: begin
                t_we   = 1'b0;
                t_addr = 2'd2;
                t_dbw  = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // CPU-visible registers
    // -----------------------------------------------------------------------
    always_comb begin
        reload_d = reload_q;
        if (wr_en && addr == 2'd0) begin
            reload_d[7:0] = dbw;
        end
        if (wr_en && addr == 2'd1) begin
            reload_d[15:8] = dbw;
        end
    end

    always_comb begin
        ctrl_d = ctrl_q;
        if (ctrl_wr) begin
            ctrl_d = dbw[2:0];
        end else if (expire && !ctrl_q[C_PERIOD]) begin
            ctrl_d[C_RUN] = 1'b0;
        end
    end

    // Expiry is applied after the clear so that set wins.
    always_comb begin
        pend_d = pend_q;
        if (stat_wr && dbw[7]) begin
            pend_d = 1'b0;
        end
        if (expire) begin
            pend_d = 1'b1;
        end
    end

`ifdef TIMER_CTL_OVERRUN_EN
    logic ovr_q, ovr_d;

    always_comb begin
        ovr_d = ovr_q;
        if (stat_wr && dbw[6]) begin
            ovr_d = 1'b0;
        end
        if (expire && pend_q) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign ovr = ovr_q;
`else
    assign ovr = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        case (addr)
            2'd0:    rdata = reload_q[7:0];
            2'd1:    rdata = reload_q[15:8];
            2'd2:    rdata = {5'b0, ctrl_q};
            default: rdata = {pend_q, ovr, 4'b0, busy, ctrl_q[C_RUN]};
        endcase
    end

    always_comb begin
        dbr_d = dbr_q;
        if (rd_en) begin
            dbr_d = rdata;
        end
    end

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            halt_q       <= 1'b0;
            poll_valid_q <= 1'b0;
            reload_q     <= RELOAD_RST;
            ctrl_q       <= CTRL_RST;
            pend_q       <= 1'b0;
            dbr_q        <= '0;
        end else begin
            state_q      <= state_d;
            halt_q       <= halt_d;
            poll_valid_q <= poll_valid_d;
            reload_q     <= reload_d;
            ctrl_q       <= ctrl_d;
            pend_q       <= pend_d;
            dbr_q        <= dbr_d;
        end
    end

    assign dbr = dbr_q;
    assign irq = pend_q & ctrl_q[C_IRQEN];

endmodule

// File: tb/tb_timer_ctl.sv
module tb_timer_ctl;

    logic       clk;
    logic       rst;
    logic       cs;
    logic       we;
    logic [1:0] addr;
    logic [7:0] dbw;
    logic [7:0] dbr;
    logic       irq;
    logic [1:0] t_addr;
    logic       t_we;
    logic [7:0] t_dbw;
    logic [7:0] t_dbr;

    timer_ctl #(
        .RELOAD_RST(16'hFFFF),
        .CTRL_RST  (3'b000)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .cs    (cs),
        .we    (we),
        .addr  (addr),
        .dbw   (dbw),
        .dbr   (dbr),
        .irq   (irq),
        .t_addr(t_addr),
        .t_we  (t_we),
        .t_dbw (t_dbw),
        .t_dbr (t_dbr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Timer model: write addr2 sets active from bit0 and clears count/shot.
    // While active the counter counts up to RELOAD, then shot latches.
    // Reads are registered: t_dbr updates on edges without a write.
    logic [7:0]  tm_lo, tm_hi;
    logic        tm_active, tm_shot;
    logic [15:0] tm_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tm_lo     <= '0;
            tm_hi     <= '0;
            tm_active <= 1'b0;
            tm_shot   <= 1'b0;
            tm_cnt    <= '0;
            t_dbr     <= '0;
        end else if (t_we) begin
            case (t_addr)
                2'd0: tm_lo <= t_dbw;
                2'd1: tm_hi <= t_dbw;
                2'd2: begin
                    tm_active <= t_dbw[0];
                    tm_shot   <= 1'b0;
                    tm_cnt    <= '0;
                end
                default: ;
            endcase
        end else begin
            case (t_addr)
                2'd0:    t_dbr <= tm_lo;
                2'd1:    t_dbr <= tm_hi;
                2'd2:    t_dbr <= {tm_shot, 6'b0, tm_active};
                default: t_dbr <= '0;
            endcase
            if (tm_active) begin
                if (tm_cnt == {tm_hi, tm_lo}) tm_shot <= 1'b1;
                else tm_cnt <= tm_cnt + 16'd1;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Scoreboard queues
    typedef struct {
        logic [1:0] a;
        logic [7:0] d;
        int         c;
    } tw_t;

    tw_t        tw_q[$];
    int         irq_q[$];
    logic [7:0] rd_q[$];

    task automatic push_tw(input int c, input logic [1:0] a, input logic [7:0] d);
        tw_t e;
        e.a = a;
        e.d = d;
        e.c = c;
        tw_q.push_back(e);
    endtask

    // Full load sequence following a CTRL/expiry decision at cycle c.
    task automatic push_load(input int c, input logic [15:0] n);
        push_tw(c + 1, 2'd2, 8'h00);
        push_tw(c + 2, 2'd0, n[7:0]);
        push_tw(c + 3, 2'd1, n[15:8]);
        push_tw(c + 4, 2'd2, 8'h01);
    endtask

    // Monitors
    logic rd_pend = 1'b0;
    logic irq_prev = 1'b0;
    always @(posedge clk) rd_pend <= cs && !we;

    always @(negedge clk) begin
        if (rd_pend) begin
            if (rd_q.size() == 0) check("rd_q_nonempty", rd_q.size(), 1);
            else check("cpu_read", dbr, rd_q.pop_front());
        end
        if (t_we) begin
            if (tw_q.size() == 0) begin
                check("tw_q_nonempty", tw_q.size(), 1);
            end else begin
                tw_t e;
                e = tw_q.pop_front();
                check("tw_cycle", cyc, e.c);
                check("tw_addr", t_addr, e.a);
                check("tw_data", t_dbw, e.d);
            end
        end
        if (irq && !irq_prev) begin
            if (irq_q.size() == 0) check("irq_q_nonempty", irq_q.size(), 1);
            else check("irq_rise_cycle", cyc, irq_q.pop_front());
        end
        irq_prev <= irq;
    end

    // CPU bus tasks; callers sit 1 ns after a rising edge.
    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d);
        cs   = 1'b1;
        we   = 1'b1;
        addr = a;
        dbw  = d;
        @(posedge clk);
        #1;
        cs = 1'b0;
        we = 1'b0;
    endtask

    task automatic cpu_rd(input logic [1:0] a, input logic [7:0] exp);
        cs   = 1'b1;
        we   = 1'b0;
        addr = a;
        rd_q.push_back(exp);
        @(posedge clk);
        #1;
        cs = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        logic [7:0] exp_ovr;

        rst  = 1'b1;
        cs   = 1'b0;
        we   = 1'b0;
        addr = '0;
        dbw  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dbr", dbr, 8'h00);
        check("rst_irq", irq, 1'b0);
        check("rst_t_we", t_we, 1'b0);
        check("rst_t_addr", t_addr, 2'd2);
        rst = 1'b0;
        @(posedge clk);
        #1;

        cpu_rd(2'd3, 8'h00);
        cpu_rd(2'd0, 8'hFF);
        cpu_rd(2'd1, 8'hFF);
        cpu_rd(2'd2, 8'h00);

        // Periodic, N=5: period 12, pend at CTRL-write cycle + 13.
        cpu_wr(2'd0, 8'h05);
        cpu_wr(2'd1, 8'h00);
        c = cyc;
        push_load(c, 16'h0005);
        push_load(c + 12, 16'h0005);
        push_load(c + 24, 16'h0005);
        push_tw(c + 31, 2'd2, 8'h00);
        irq_q.push_back(c + 13);
        irq_q.push_back(c + 25);
        cpu_wr(2'd2, 8'h07);
        wait_cyc(c + 13);
        cpu_rd(2'd3, 8'h83);
        cpu_wr(2'd3, 8'h80);
        wait_cyc(c + 30);
        cpu_wr(2'd2, 8'h00);
        wait_cyc(c + 32);
        check("halt_t_we", t_we, 1'b0);
        cpu_rd(2'd3, 8'h80);
        cpu_wr(2'd3, 8'h80);

        // One-shot, N=3: pend at c+11 together with the halting stop write.
        cpu_wr(2'd0, 8'h03);
        c = cyc;
        push_load(c, 16'h0003);
        push_tw(c + 11, 2'd2, 8'h00);
        irq_q.push_back(c + 11);
        cpu_wr(2'd2, 8'h05);
        wait_cyc(c + 12);
        cpu_rd(2'd3, 8'h80);
        cpu_rd(2'd2, 8'h04);
        cpu_wr(2'd3, 8'h80);
        cpu_rd(2'd3, 8'h00);
        check("oneshot_irq_clr", irq, 1'b0);

        // Pend clear on the exact expiry edge, then an unacknowledged expiry.
        cpu_wr(2'd0, 8'h05);
        c = cyc;
        push_load(c, 16'h0005);
        push_load(c + 12, 16'h0005);
        push_load(c + 24, 16'h0005);
        push_tw(c + 31, 2'd2, 8'h00);
        irq_q.push_back(c + 13);
        cpu_wr(2'd2, 8'h07);
        wait_cyc(c + 12);
        cpu_wr(2'd3, 8'h80);
        cpu_rd(2'd3, 8'h83);
`ifdef TIMER_CTL_OVERRUN_EN
        exp_ovr = 8'hC3;
`else
        exp_ovr = 8'h83;
`endif
        wait_cyc(c + 26);
        cpu_rd(2'd3, exp_ovr);
        cpu_wr(2'd3, 8'h40);
        cpu_rd(2'd3, 8'h83);
        wait_cyc(c + 30);
        cpu_wr(2'd2, 8'h00);
        wait_cyc(c + 32);
        cpu_wr(2'd3, 8'h80);

        // Reset asserted during LD_HI.
        c = cyc;
        push_tw(c + 1, 2'd2, 8'h00);
        push_tw(c + 2, 2'd0, 8'h05);
        cpu_wr(2'd2, 8'h07);
        wait_cyc(c + 3);
        #1;
        rst = 1'b1;
        #1;
        check("rstmid_t_we", t_we, 1'b0);
        check("rstmid_t_addr", t_addr, 2'd2);
        check("rstmid_dbr", dbr, 8'h00);
        check("rstmid_irq", irq, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        cpu_rd(2'd2, 8'h00);
        cpu_rd(2'd3, 8'h00);
        cpu_rd(2'd0, 8'hFF);
        cpu_rd(2'd1, 8'hFF);
        repeat (4) @(posedge clk);
        #1;

        check("tw_left", tw_q.size(), 0);
        check("irq_left", irq_q.size(), 0);
        check("rd_left", rd_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
